// File: rtl/accumulate_par.sv
// accumulate_par: walks an internal single-port array over [init_i, end_i), folding each element
// into a running accumulator (wrapping sum, saturating sum or signed max) and writing the running
// value back in place. A host preloads and inspects the array through the controlArr side port.
//
// Ports
//   clk                  single clock, all state on posedge
//   r_enable             synchronous active-high reset; also captures the run arguments
//   controlArr           host owns the array; the engine stalls while high
//   init_i / end_i       first index / exclusive end index (captured while r_enable=1)
//   mode                 0 wrap sum, 1 saturating sum, 2 signed max, 3 same as 0
//   init_acc             initial accumulator value
//   controlArrWEnable_a  host write enable
//   controlArrAddr_a     host address
//   controlArrWData_a    host write data
//   controlArrRData_a    host read data, one cycle after the address; undefined when controlArr=0
//   w_enable             run complete, sticky until the next r_enable
//   result               final accumulator
//   overflow             sticky signed-overflow flag (modes 0 and 1)
module accumulate_par #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1000
) (
  input  logic              clk,
  input  logic              r_enable,
  input  logic              controlArr,
  input  logic [ADDR_W-1:0] init_i,
  input  logic [ADDR_W:0]   end_i,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] init_acc,
  input  logic              controlArrWEnable_a,
  input  logic [ADDR_W-1:0] controlArrAddr_a,
  output logic [DATA_W-1:0] controlArrRData_a,
  input  logic [DATA_W-1:0] controlArrWData_a,
  output logic              w_enable,
  output logic [DATA_W-1:0] result,
  output logic              overflow
);

  typedef enum logic [2:0] {StCheck, StRead, StAcc, StWrite, StDone} state_e;

  localparam logic [ADDR_W:0]   DepthL = (ADDR_W + 1)'(DEPTH);
  localparam logic [DATA_W-1:0] SatMax = {1'b0, {(DATA_W - 1){1'b1}}};
  localparam logic [DATA_W-1:0] SatMin = {1'b1, {(DATA_W - 1){1'b0}}};

  state_e              state_q, state_d;
  // i and end are one bit wider than the address so that end == DEPTH == 2^ADDR_W is representable
  logic [ADDR_W:0]     i_q;
  logic [ADDR_W:0]     end_q;
  logic [1:0]          mode_q;
  logic [DATA_W-1:0]   acc_q;
  logic                w_enable_q;
  logic [DATA_W-1:0]   result_q;
  logic                overflow_q;
  logic                stall_prev_q;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   raddr_q;
  logic [DATA_W-1:0]   rdata;

  logic                engine_go;
  logic                eng_rd, eng_wr;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_we, mem_re;
  logic [DATA_W-1:0]   mem_wdata;
  logic                addr_in_range;

  logic [DATA_W-1:0]   sum;
  logic                add_ovf;
  logic [DATA_W-1:0]   fold_val;
  logic                fold_ovf;
  logic [ADDR_W:0]     end_clamped;

  // ---------------------------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (r_enable) begin
      state_q <= StCheck;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (!controlArr) begin
      unique case (state_q)
        StCheck: state_d = (i_q < end_q) ? StRead : StDone;
        StRead:  state_d = StAcc;
        // A host access in the previous cycle may have replaced the registered read address,
        // so the element is fetched again before it is folded.
        StAcc:   state_d = stall_prev_q ? StRead : StWrite;
        StWrite: state_d = StCheck;
        StDone:  state_d = StDone;
        default: state_d = StCheck;
      endcase
    end
  end

  // ---------------------------------------------------------------------------------------------
  // FSM: outputs (memory port arbitration)
  // ---------------------------------------------------------------------------------------------
  assign engine_go = !r_enable && !controlArr;

  always_comb begin
    eng_rd    = 1'b0;
    eng_wr    = 1'b0;
    mem_addr  = i_q[ADDR_W-1:0];
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_wdata = acc_q;
    if (engine_go) begin
      eng_rd = (state_q == StRead);
      eng_wr = (state_q == StWrite);
    end
    if (controlArr) begin
      // Host access proceeds even while r_enable holds the engine in reset.
      mem_addr  = controlArrAddr_a;
      mem_we    = controlArrWEnable_a;
      mem_re    = !controlArrWEnable_a;
      mem_wdata = controlArrWData_a;
    end else begin
      mem_we = eng_wr;
      mem_re = eng_rd;
    end
  end

  assign addr_in_range = ({1'b0, mem_addr} < DepthL);

  // ---------------------------------------------------------------------------------------------
  // Single-port array: synchronous write, registered read address
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (mem_we && addr_in_range) begin
      mem[mem_addr] <= mem_wdata;
    end
    if (mem_re) begin
      raddr_q <= mem_addr;
    end
  end

  assign rdata             = mem[raddr_q];
  assign controlArrRData_a = rdata;

  // ---------------------------------------------------------------------------------------------
  // Fold function
  // ---------------------------------------------------------------------------------------------
  assign sum     = acc_q + rdata;
  assign add_ovf = (acc_q[DATA_W-1] == rdata[DATA_W-1]) && (sum[DATA_W-1] != acc_q[DATA_W-1]);

  always_comb begin
    fold_val = sum;
    fold_ovf = add_ovf;
    case (mode_q)
      2'd1: begin
        // On overflow both operands share a sign, so the clamp direction follows acc's sign.
        if (add_ovf) begin
          fold_val = acc_q[DATA_W-1] ? SatMin : SatMax;
        end
      end
      2'd2: begin
        fold_val = ($signed(rdata) > $signed(acc_q)) ? rdata : acc_q;
        fold_ovf = 1'b0;
      end
      default: begin
        fold_val = sum;
        fold_ovf = add_ovf;
      end
    endcase
  end

  assign end_clamped = (end_i > DepthL) ? DepthL : end_i;

  // ---------------------------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (r_enable) begin
      i_q          <= {1'b0, init_i};
      end_q        <= end_clamped;
      mode_q       <= mode;
      acc_q        <= init_acc;
      w_enable_q   <= 1'b0;
      result_q     <= '0;
      overflow_q   <= 1'b0;
      stall_prev_q <= 1'b0;
    end else begin
      stall_prev_q <= controlArr;
      if (!controlArr) begin
        unique case (state_q)
          StAcc: begin
            if (!stall_prev_q) begin
              acc_q <= fold_val;
              if (fold_ovf) begin
                overflow_q <= 1'b1;
              end
            end
          end
          StWrite: i_q <= i_q + 1'b1;
          StDone: begin
            w_enable_q <= 1'b1;
            result_q   <= acc_q;
          end
          default: ;
        endcase
      end
    end
  end

  assign w_enable = w_enable_q;
  assign result   = result_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_accumulate_par.sv
// Self-checking bench for accumulate_par: directed cases followed by randomized runs, all checked
// against a reference array model kept in the bench.
module tb_accumulate_par;

  localparam int DW    = 64;
  localparam int AW    = 10;
  localparam int DEPTH = 1000;

  localparam logic signed [64:0] MaxV = 65'sh0_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [64:0] MinV = 65'sh1_8000_0000_0000_0000;

  logic          clk = 1'b0;
  logic          r_enable = 1'b1;
  logic          controlArr = 1'b0;
  logic [AW-1:0] init_i = '0;
  logic [AW:0]   end_i = '0;
  logic [1:0]    mode = '0;
  logic [DW-1:0] init_acc = '0;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_rdata;
  logic [DW-1:0] host_wdata = '0;
  logic          w_enable;
  logic [DW-1:0] result;
  logic          overflow;

  always #5 clk = ~clk;

  accumulate_par #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .DEPTH (DEPTH)
  ) dut (
    .clk                (clk),
    .r_enable           (r_enable),
    .controlArr         (controlArr),
    .init_i             (init_i),
    .end_i              (end_i),
    .mode               (mode),
    .init_acc           (init_acc),
    .controlArrWEnable_a(host_we),
    .controlArrAddr_a   (host_addr),
    .controlArrRData_a  (host_rdata),
    .controlArrWData_a  (host_wdata),
    .w_enable           (w_enable),
    .result             (result),
    .overflow           (overflow)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] ref_mem [DEPTH];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input int a, input logic [DW-1:0] d);
    controlArr = 1'b1;
    host_we    = 1'b1;
    host_addr  = AW'(a);
    host_wdata = d;
    tick();
    host_we    = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic host_read(input int a, output logic [DW-1:0] d);
    controlArr = 1'b1;
    host_we    = 1'b0;
    host_addr  = AW'(a);
    tick();
    d = host_rdata;
  endtask

  // Reference fold: exact arithmetic on a wider signed value, then wrap / clamp / max.
  function automatic logic [DW-1:0] fold_f(input logic [DW-1:0] acc, input logic [DW-1:0] x,
                                           input logic [1:0] m, output bit ov);
    logic signed [64:0] wide;
    wide = 65'($signed(acc)) + 65'($signed(x));
    if (m == 2'd2) begin
      ov = 1'b0;
      return ($signed(x) > $signed(acc)) ? x : acc;
    end
    ov = (wide > MaxV) || (wide < MinV);
    if (m == 2'd1 && ov) return (wide > MaxV) ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h8000_0000_0000_0000;
    return wide[63:0];
  endfunction

  task automatic model_run(input int ii, input int ee, input logic [1:0] m,
                           input logic [DW-1:0] a0, output logic [DW-1:0] res, output bit ov);
    logic [DW-1:0] acc;
    bit o;
    int hi;
    acc = a0;
    ov  = 1'b0;
    hi  = (ee > DEPTH) ? DEPTH : ee;
    for (int k = ii; k < hi; k++) begin
      acc        = fold_f(acc, ref_mem[k], m, o);
      ref_mem[k] = acc;
      ov         = ov | o;
    end
    res = acc;
  endtask

  task automatic start_run(input int ii, input int ee, input logic [1:0] m, input logic [DW-1:0] a0);
    controlArr = 1'b0;
    host_we    = 1'b0;
    r_enable   = 1'b1;
    init_i     = AW'(ii);
    end_i      = (AW + 1)'(ee);
    mode       = m;
    init_acc   = a0;
    tick();
    check("reset w_enable", 64'(w_enable), 64'd0);
    check("reset result", result, 64'd0);
    check("reset overflow", 64'(overflow), 64'd0);
    r_enable = 1'b0;
  endtask

  // Counts posedges after r_enable falls until w_enable is seen. stall_at>0 holds controlArr high
  // for stall_len posedges starting after posedge stall_at, reading a[0] meanwhile.
  task automatic wait_done(input int stall_at, input int stall_len, input bit rnd_stall,
                           output int cyc);
    cyc = 0;
    for (int c = 1; c <= 4000; c++) begin
      if (rnd_stall) begin
        if ($urandom_range(0, 3) == 0) begin
          controlArr = 1'b1;
          host_we    = 1'b0;
          host_addr  = AW'($urandom_range(0, DEPTH - 1));
        end else begin
          controlArr = 1'b0;
        end
      end
      tick();
      if (stall_at > 0 && c == stall_at) begin
        controlArr = 1'b1;
        host_we    = 1'b0;
        host_addr  = '0;
      end
      if (stall_at > 0 && c == stall_at + 1) check("stall host read a[0]", host_rdata, 64'd11);
      if (stall_at > 0 && c == stall_at + stall_len) controlArr = 1'b0;
      if (w_enable) begin
        cyc = c;
        break;
      end
    end
    controlArr = 1'b0;
    if (cyc == 0) check("completion within budget", 64'(w_enable), 64'd1);
  endtask

  task automatic verify(input string name, input int ii, input int ee,
                        input logic [DW-1:0] exp_res, input bit exp_ov);
    logic [DW-1:0] d;
    int hi, lo, top;
    check({name, " result"}, result, exp_res);
    check({name, " overflow"}, 64'(overflow), 64'(exp_ov));
    hi  = (ee > DEPTH) ? DEPTH : ee;
    lo  = (ii > 0) ? ii - 1 : 0;
    lo  = (lo > DEPTH - 1) ? DEPTH - 1 : lo;
    top = (hi > ii + 1) ? hi : ii + 1;
    top = (top > DEPTH - 1) ? DEPTH - 1 : top;
    for (int k = lo; k <= top; k++) begin
      host_read(k, d);
      check($sformatf("%s a[%0d]", name, k), d, ref_mem[k]);
    end
    check({name, " w_enable sticky"}, 64'(w_enable), 64'd1);
    controlArr = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] exp_res, d, a0;
    bit exp_ov;
    int cyc, ii, ee, len;
    logic [1:0] m;

    // Preload the whole array while the engine is held in reset.
    r_enable = 1'b1;
    for (int k = 0; k < DEPTH; k++) host_write(k, {$urandom(), $urandom()});
    controlArr = 1'b0;

    // Prefix sum
    for (int k = 0; k < 4; k++) host_write(k, 64'(k + 1));
    model_run(0, 4, 2'd0, 64'd10, exp_res, exp_ov);
    start_run(0, 4, 2'd0, 64'd10);
    wait_done(0, 0, 1'b0, cyc);
    check("prefix latency", 64'(cyc), 64'd18);
    check("prefix result const", result, 64'd20);
    verify("prefix", 0, 4, exp_res, exp_ov);

    // Empty range
    model_run(5, 5, 2'd0, 64'd7, exp_res, exp_ov);
    start_run(5, 5, 2'd0, 64'd7);
    wait_done(0, 0, 1'b0, cyc);
    check("empty latency", 64'(cyc), 64'd2);
    verify("empty", 5, 5, 64'd7, 1'b0);

    // Saturating overflow
    host_write(0, 64'd5);
    model_run(0, 1, 2'd1, 64'h7FFF_FFFF_FFFF_FFFE, exp_res, exp_ov);
    start_run(0, 1, 2'd1, 64'h7FFF_FFFF_FFFF_FFFE);
    wait_done(0, 0, 1'b0, cyc);
    check("sat result const", result, 64'h7FFF_FFFF_FFFF_FFFF);
    verify("sat", 0, 1, exp_res, 1'b1);

    // Wrapping overflow
    host_write(0, 64'd5);
    model_run(0, 1, 2'd0, 64'h7FFF_FFFF_FFFF_FFFE, exp_res, exp_ov);
    start_run(0, 1, 2'd0, 64'h7FFF_FFFF_FFFF_FFFE);
    wait_done(0, 0, 1'b0, cyc);
    check("wrap result const", result, 64'h8000_0000_0000_0003);
    verify("wrap", 0, 1, exp_res, 1'b1);

    // Running max
    host_write(0, 64'd3);
    host_write(1, -64'sd1);
    host_write(2, 64'd9);
    host_write(3, 64'd2);
    model_run(0, 4, 2'd2, 64'd4, exp_res, exp_ov);
    start_run(0, 4, 2'd2, 64'd4);
    wait_done(0, 0, 1'b0, cyc);
    check("max result const", result, 64'd9);
    verify("max", 0, 4, exp_res, 1'b0);

    // Stall during WRITE of element 1
    for (int k = 0; k < 4; k++) host_write(k, 64'(k + 1));
    model_run(0, 4, 2'd0, 64'd10, exp_res, exp_ov);
    start_run(0, 4, 2'd0, 64'd10);
    wait_done(7, 5, 1'b0, cyc);
    check("stall latency", 64'(cyc), 64'd23);
    verify("stall", 0, 4, exp_res, exp_ov);

    // Abort during element 2 (ACC state after posedge 10)
    for (int k = 0; k < 4; k++) host_write(k, 64'(k + 1));
    start_run(0, 4, 2'd0, 64'd10);
    for (int c = 0; c < 10; c++) tick();
    r_enable = 1'b1;
    tick();
    check("abort w_enable", 64'(w_enable), 64'd0);
    check("abort result", result, 64'd0);
    ref_mem[0] = 64'd11;
    ref_mem[1] = 64'd13;
    for (int k = 0; k < 4; k++) begin
      host_read(k, d);
      check($sformatf("abort a[%0d]", k), d, ref_mem[k]);
    end
    controlArr = 1'b0;

    // Clamped end index
    m  = 2'($urandom_range(0, 3));
    a0 = {$urandom(), $urandom()};
    model_run(998, 1023, m, a0, exp_res, exp_ov);
    start_run(998, 1023, m, a0);
    wait_done(0, 0, 1'b0, cyc);
    check("clamp latency", 64'(cyc), 64'd10);
    verify("clamp", 998, 1023, exp_res, exp_ov);

    // init_i beyond DEPTH is an empty run
    model_run(1010, 1020, 2'd0, 64'd99, exp_res, exp_ov);
    start_run(1010, 1020, 2'd0, 64'd99);
    wait_done(0, 0, 1'b0, cyc);
    check("oob-start latency", 64'(cyc), 64'd2);
    check("oob-start result", result, 64'd99);

    // Randomized runs, half with random host stalls
    for (int r = 0; r < 8; r++) begin
      ii  = $urandom_range(0, 990);
      len = $urandom_range(0, 30);
      ee  = ii + len;
      m   = 2'($urandom_range(0, 3));
      a0  = {$urandom(), $urandom()};
      model_run(ii, ee, m, a0, exp_res, exp_ov);
      start_run(ii, ee, m, a0);
      wait_done(0, 0, r[0], cyc);
      if (!r[0]) begin
        len = ((ee > DEPTH) ? DEPTH : ee) - ii;
        check($sformatf("rand%0d latency", r), 64'(cyc), 64'(4 * len + 2));
      end
      verify($sformatf("rand%0d", r), ii, ee, exp_res, exp_ov);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
